// File: rtl/palette_lut_if.sv
// Bundle of the palette write, commit and pixel lookup signals between a
// controller (master) and palette_lut (slave).
interface palette_lut_if #(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24,
  parameter int NUM_PAL = 4
) ();
  localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;

  // Write handshake: a write transfers on every clock edge where
  // i_wr_valid & o_wr_ready. While waiting, the master holds the payload
  // stable. Ready never depends on valid.
  logic               i_wr_valid;
  logic               o_wr_ready;
  logic [PAL_W-1:0]   i_wr_pal;
  logic [IDX_W-1:0]   i_wr_idx;
  logic [COLOR_W-1:0] i_wr_color;

  logic               i_commit;
  logic               o_busy;
  logic               o_commit_done;

  logic               i_px_valid;
  logic [PAL_W-1:0]   i_px_pal;
  logic [IDX_W-1:0]   i_px_idx;
  logic               i_flash;
  logic               o_px_valid;
  logic [COLOR_W-1:0] o_px_color;
  logic               o_px_transparent;

  logic               o_dbg_state;

  modport master (
    output i_wr_valid, i_wr_pal, i_wr_idx, i_wr_color, i_commit,
           i_px_valid, i_px_pal, i_px_idx, i_flash,
    input  o_wr_ready, o_busy, o_commit_done,
           o_px_valid, o_px_color, o_px_transparent, o_dbg_state
  );

  modport slave (
    input  i_wr_valid, i_wr_pal, i_wr_idx, i_wr_color, i_commit,
           i_px_valid, i_px_pal, i_px_idx, i_flash,
    output o_wr_ready, o_busy, o_commit_done,
           o_px_valid, o_px_color, o_px_transparent, o_dbg_state
  );
endinterface

// File: rtl/palette_lut.sv
// Multi-palette colour lookup with a shadow/active register pair: writes land
// in shadow, a commit copies shadow into active one entry per cycle.
module palette_lut #(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24,
  parameter int NUM_PAL = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  palette_lut_if.slave  bus
);
  localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               done_q;

  logic [COLOR_W-1:0] shadow_q [NUM_PAL][DEPTH];
  logic [COLOR_W-1:0] active_q [NUM_PAL][DEPTH];

  logic               s1_valid_q;
  logic [PAL_W-1:0]   s1_pal_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic               s1_flash_q;
  logic               px_valid_q;
  logic [COLOR_W-1:0] px_color_q;
  logic               px_transp_q;

  logic               wr_fire;
  logic               wr_pal_ok;
  logic               s1_pal_ok;
  logic [COLOR_W-1:0] lk_raw;
  logic [COLOR_W-1:0] lk_color_d;
  logic               lk_transp_d;

  assign wr_fire   = bus.i_wr_valid & (state_q == S_IDLE);
  assign wr_pal_ok = (32'(bus.i_wr_pal) < NUM_PAL);
  assign s1_pal_ok = (32'(s1_pal_q) < NUM_PAL);

  // Commit FSM owns both arrays; the copy moves one index of every palette per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int k = 0; k < DEPTH; k++) begin
          shadow_q[p][k] <= '0;
          active_q[p][k] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_fire && wr_pal_ok) begin
            shadow_q[bus.i_wr_pal][bus.i_wr_idx] <= bus.i_wr_color;
          end
          if (bus.i_commit) begin
            state_q <= S_COPY;
            cnt_q   <= '0;
          end
        end
        S_COPY: begin
          for (int p = 0; p < NUM_PAL; p++) begin
            active_q[p][cnt_q] <= shadow_q[p][cnt_q];
          end
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    lk_raw = '0;
    if (s1_pal_ok) begin
      lk_raw = active_q[s1_pal_q][s1_idx_q];
    end
    lk_transp_d = (s1_idx_q == '0) | ~s1_pal_ok;
    if (lk_transp_d) begin
      lk_color_d = '0;
    end else if (s1_flash_q) begin
      lk_color_d = '1;
    end else begin
      lk_color_d = lk_raw;
    end
  end

  // Colour and transparency hold their last values on bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_pal_q    <= '0;
      s1_idx_q    <= '0;
      s1_flash_q  <= 1'b0;
      px_valid_q  <= 1'b0;
      px_color_q  <= '0;
      px_transp_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.i_px_valid;
      s1_pal_q   <= bus.i_px_pal;
      s1_idx_q   <= bus.i_px_idx;
      s1_flash_q <= bus.i_flash;
      px_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        px_color_q  <= lk_color_d;
        px_transp_q <= lk_transp_d;
      end
    end
  end

  assign bus.o_wr_ready       = (state_q == S_IDLE);
  assign bus.o_busy           = (state_q == S_COPY);
  assign bus.o_commit_done    = done_q;
  assign bus.o_px_valid       = px_valid_q;
  assign bus.o_px_color       = px_color_q;
  assign bus.o_px_transparent = px_transp_q;
  assign bus.o_dbg_state      = state_q;
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: reset, shadow/commit behaviour, transparency,
// flash, commit during copy, pixel streaming and reset mid-copy.
module tb_palette_lut;
  localparam int IDX_W   = 4;
  localparam int COLOR_W = 24;
  localparam int NUM_PAL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  palette_lut_if #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .NUM_PAL(NUM_PAL)) bus ();

  palette_lut #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .NUM_PAL(NUM_PAL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [COLOR_W-1:0] mdl [NUM_PAL][16];
  logic [COLOR_W:0]   exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLOR_W:0] model(input logic [1:0] pal, input logic [3:0] idx,
                                              input logic fl);
    if (idx == 4'd0) return {1'b1, {COLOR_W{1'b0}}};
    if (fl) return {1'b0, {COLOR_W{1'b1}}};
    return {1'b0, mdl[pal][idx]};
  endfunction

  task automatic idle_inputs();
    bus.i_wr_valid = 1'b0;
    bus.i_wr_pal   = '0;
    bus.i_wr_idx   = '0;
    bus.i_wr_color = '0;
    bus.i_commit   = 1'b0;
    bus.i_px_valid = 1'b0;
    bus.i_px_pal   = '0;
    bus.i_px_idx   = '0;
    bus.i_flash    = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] pal, input logic [3:0] idx, input logic fl,
                        input logic [23:0] ec, input logic et, input string tag);
    bus.i_px_valid = 1'b1;
    bus.i_px_pal   = pal;
    bus.i_px_idx   = idx;
    bus.i_flash    = fl;
    step();
    bus.i_px_valid = 1'b0;
    bus.i_flash    = 1'b0;
    check({tag, "_early"}, 32'(bus.o_px_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(bus.o_px_valid), 32'd1);
    check({tag, "_color"}, 32'(bus.o_px_color), 32'(ec));
    check({tag, "_transp"}, 32'(bus.o_px_transparent), 32'(et));
    step();
  endtask

  task automatic write_entry(input logic [1:0] pal, input logic [3:0] idx, input logic [23:0] c);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_pal   = pal;
    bus.i_wr_idx   = idx;
    bus.i_wr_color = c;
    step();
    bus.i_wr_valid = 1'b0;
  endtask

  // Called in the first cycle after the commit edge.
  task automatic wait_copy(input string tag);
    int busy_n = 0;
    int rdy_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.o_busy) break;
      busy_n++;
      if (!bus.o_wr_ready) rdy_low++;
      step();
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
    check({tag, "_ready_low"}, 32'(rdy_low), 32'd16);
    check({tag, "_done"}, 32'(bus.o_commit_done), 32'd1);
    check({tag, "_ready_back"}, 32'(bus.o_wr_ready), 32'd1);
    step();
    check({tag, "_done_pulse"}, 32'(bus.o_commit_done), 32'd0);
  endtask

  task automatic commit_and_wait(input string tag);
    bus.i_commit = 1'b1;
    step();
    bus.i_commit = 1'b0;
    wait_copy(tag);
  endtask

  initial begin
    int done_n;
    int n_out;
    int first_i;
    int last_i;
    logic [1:0] pal;
    logic [3:0] idx;
    logic fl;
    logic [COLOR_W:0] got;
    logic [COLOR_W:0] want;

    for (int p = 0; p < NUM_PAL; p++)
      for (int k = 0; k < 16; k++) mdl[p][k] = '0;
    idle_inputs();

    // Reset state
    repeat (3) step();
    check("rst_px_valid", 32'(bus.o_px_valid), 32'd0);
    check("rst_px_color", 32'(bus.o_px_color), 32'd0);
    check("rst_px_transp", 32'(bus.o_px_transparent), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_commit_done), 32'd0);
    check("rst_wr_ready", 32'(bus.o_wr_ready), 32'd1);
    check("rst_state", 32'(bus.o_dbg_state), 32'd0);
    rst_n = 1'b1;
    step();

    lookup(2'd1, 4'd5, 1'b0, 24'h0, 1'b0, "rst_lookup");

    // Shadow write is invisible until commit
    write_entry(2'd2, 4'd3, 24'hf7d667);
    lookup(2'd2, 4'd3, 1'b0, 24'h0, 1'b0, "pre_commit");
    commit_and_wait("commit1");
    mdl[2][3] = 24'hf7d667;
    lookup(2'd2, 4'd3, 1'b0, 24'hf7d667, 1'b0, "post_commit");

    // Transparency and flash
    write_entry(2'd2, 4'd0, 24'h311b58);
    commit_and_wait("commit2");
    mdl[2][0] = 24'h311b58;
    lookup(2'd2, 4'd0, 1'b0, 24'h0, 1'b1, "idx0_transp");
    lookup(2'd2, 4'd3, 1'b1, 24'hffffff, 1'b0, "flash");
    lookup(2'd2, 4'd0, 1'b1, 24'h0, 1'b1, "flash_idx0");

    // Writes and a second commit during COPY are ignored
    bus.i_commit = 1'b1;
    step();
    bus.i_commit   = 1'b0;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_pal   = 2'd1;
    bus.i_wr_idx   = 4'd5;
    bus.i_wr_color = 24'h123456;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) check("copy_wr_ready", 32'(bus.o_wr_ready), 32'd0);
      bus.i_commit = (i == 3);
      step();
      if (!bus.o_busy) bus.i_wr_valid = 1'b0;
      if (bus.o_commit_done) done_n++;
    end
    bus.i_commit = 1'b0;
    check("copy_single_done", 32'(done_n), 32'd1);
    check("copy_state_idle", 32'(bus.o_dbg_state), 32'd0);
    commit_and_wait("commit3");
    lookup(2'd1, 4'd5, 1'b0, 24'h0, 1'b0, "shadow_untouched");

    // Write and commit in the same cycle
    bus.i_wr_valid = 1'b1;
    bus.i_wr_pal   = 2'd0;
    bus.i_wr_idx   = 4'hf;
    bus.i_wr_color = 24'h5d4888;
    bus.i_commit   = 1'b1;
    step();
    bus.i_wr_valid = 1'b0;
    bus.i_commit   = 1'b0;
    wait_copy("wr_commit");
    mdl[0][15] = 24'h5d4888;
    lookup(2'd0, 4'hf, 1'b0, 24'h5d4888, 1'b0, "same_cycle");

    // Back-to-back stream of 20 pixels
    n_out   = 0;
    first_i = -1;
    last_i  = -1;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) begin
        pal = (i % 2 == 1) ? 2'd2 : 2'd0;
        idx = 4'(i * 7);
        fl  = (i % 5 == 4);
        bus.i_px_valid = 1'b1;
        bus.i_px_pal   = pal;
        bus.i_px_idx   = idx;
        bus.i_flash    = fl;
        exp_q.push_back(model(pal, idx, fl));
      end else begin
        bus.i_px_valid = 1'b0;
        bus.i_flash    = 1'b0;
      end
      step();
      if (bus.o_px_valid) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        n_out++;
        got = {bus.o_px_transparent, bus.o_px_color};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("stream_px", 32'(got), 32'(want));
      end
    end
    check("stream_count", 32'(n_out), 32'd20);
    check("stream_first", 32'(first_i), 32'd1);
    check("stream_last", 32'(last_i), 32'd20);

    // Reset asserted at copy cycle 7
    bus.i_commit = 1'b1;
    step();
    bus.i_commit = 1'b0;
    repeat (7) step();
    check("midcopy_busy_before", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midcopy_busy", 32'(bus.o_busy), 32'd0);
    check("midcopy_wr_ready", 32'(bus.o_wr_ready), 32'd1);
    check("midcopy_done", 32'(bus.o_commit_done), 32'd0);
    done_n = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) rst_n = 1'b1;
      step();
      if (bus.o_commit_done) done_n++;
    end
    check("midcopy_no_done", 32'(done_n), 32'd0);
    lookup(2'd2, 4'd3, 1'b0, 24'h0, 1'b0, "post_reset_a");
    lookup(2'd0, 4'hf, 1'b0, 24'h0, 1'b0, "post_reset_b");
    commit_and_wait("commit_after_reset");
    lookup(2'd2, 4'd3, 1'b0, 24'h0, 1'b0, "post_reset_shadow");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
# palette_lut

Runtime-loadable, multi-palette colour lookup for the sprite/decoder path, generalising the fixed 16-entry ROM palettes. It holds NUM_PAL palettes of 2^IDX_W entries each in a shadow/active register pair. Palette writes always go to the shadow copy, and a commit (normally VGA vsync) copies the shadow into the active copy. A 2-stage pipelined lookup turns (palette, index) pixels into COLOR_W-bit colours with a transparency flag and a hit-flash override.

## Interface
- IDX_W, 4, pixel index width; each palette has 2^IDX_W entries
- COLOR_W, 24, colour width (RGB888 by default)
- NUM_PAL, 4, number of palettes; PAL_W = max(1, $clog2(NUM_PAL)) is derived
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_wr_valid  in  1  palette write request
- o_wr_ready  out  1  write accepted when i_wr_valid & o_wr_ready
- i_wr_pal  in  PAL_W  palette number to write
- i_wr_idx  in  IDX_W  entry number to write
- i_wr_color  in  COLOR_W  colour to write
- i_commit  in  1  pulse; starts the shadow→active copy
- o_busy  out  1  copy in progress
- o_commit_done  out  1  one-cycle pulse when the copy finishes
- i_px_valid  in  1  lookup request
- i_px_pal  in  PAL_W  palette select
- i_px_idx  in  IDX_W  pixel index
- i_flash  in  1  hit-flash: non-transparent pixels output all-ones
- o_px_valid  out  1  lookup result valid
- o_px_color  out  COLOR_W  looked-up colour
- o_px_transparent  out  1  pixel is transparent

## Operation
- Storage: shadow[NUM_PAL][2^IDX_W] and active[NUM_PAL][2^IDX_W], both COLOR_W wide.
- Reset clears both arrays, the FSM goes to IDLE, the copy counter goes to 0, and every registered output is 0.
- FSM states are IDLE and COPY.
  - o_wr_ready = (state == IDLE), combinational.
  - o_busy = (state == COPY).
- Writes:
  - In IDLE, an accepted write updates shadow[i_wr_pal][i_wr_idx] at the clock edge.
  - If i_wr_pal ≥ NUM_PAL, the write is accepted and dropped.
- Commit:
  - i_commit sampled high in IDLE moves the FSM to COPY with the counter at 0.
  - i_commit sampled in COPY is ignored; it is not queued.
- COPY, on each cycle k = 0..2^IDX_W−1: active[p][k] <= shadow[p][k] for all p in parallel.
  - After k = 2^IDX_W−1 the FSM returns to IDLE.
  - o_commit_done pulses high for the first IDLE cycle after the copy.
- Write and commit in the same IDLE cycle: the write is accepted and is included in the copy.
- Lookup runs independently of the FSM and always reads active.
  - During COPY a pixel can see a mix of old and new entries. This is allowed because commit is aligned to vsync.
- Transparency: index 0 is transparent regardless of its stored content.
  - o_px_transparent = (idx == 0) | (pal ≥ NUM_PAL).
  - When transparent, o_px_color = 0.
- Flash: when the flash bit is set and the pixel is not transparent, o_px_color = all-ones. Transparency is unchanged.
- Reset asserted mid-copy aborts the copy: arrays are cleared, the FSM goes to IDLE, and no o_commit_done pulse is produced.

## Timing
- Lookup latency is 2 cycles, fully pipelined at 1 pixel per cycle with no stall.
  - Stage 1 registers valid, pal, idx and flash at edge t.
  - Stage 2 registers colour, transparency and valid at edge t+1.
  - A request presented before edge t appears on the outputs after edge t+1, i.e. it is visible in cycle t+2.
- o_px_valid follows i_px_valid delayed by 2. When valid is 0, colour and transparency hold their last values.
- Write: takes effect at the accepting edge. A lookup issued in the same cycle still reads the old active value.
- Commit timing, with i_commit at edge c:
  - o_busy is high in cycles c+1 .. c+2^IDX_W.
  - o_commit_done is high in cycle c+2^IDX_W+1.
  - o_wr_ready is low for exactly 2^IDX_W cycles.
- A new commit is accepted in the same cycle as o_commit_done.
- The copy counter is IDX_W bits wide and wraps to 0 when the copy ends.

## Test plan
- Reset then lookup (pal 1, idx 5) → after 2 cycles o_px_valid=1, o_px_color=0, o_px_transparent=0. All outputs 0 during reset.
- Write pal 2 idx 3 = 24'hf7d667, look it up before commit → 0. Commit, wait for o_commit_done → the lookup returns 24'hf7d667. o_busy is high for exactly 16 cycles (IDX_W=4).
- Write idx 0 = 24'h311b58 then commit → lookup of idx 0 gives transparent=1, color=0. With i_flash=1, idx 3 gives 24'hffffff and idx 0 stays transparent.
- During COPY: i_wr_valid held high → o_wr_ready=0 and shadow is unchanged. A second i_commit is ignored, so there is only one o_commit_done pulse.
- Write and commit in the same cycle to pal 0 idx 0xF = 24'h5d4888 → after done, the lookup returns 24'h5d4888. A back-to-back pixel stream of 20 valids gives 20 results with exactly a 2-cycle offset.
- Assert i_rst_n low at copy cycle 7 → o_busy=0 at once, no o_commit_done pulse, and after release all lookups return 0.
